// File: rtl/pipeline_stage_controller_if.sv
// Hazard inputs and register enable/clear outputs shared between the pipeline and
// its stage controller.
interface pipeline_stage_controller_if #(
  parameter int unsigned PERF_WIDTH = 16
) ();
  logic                  mem_wait_in;
  logic                  mul_start_in;
  logic                  branch_taken_in;
  logic                  pc_en_out;
  logic                  ifid_en_out;
  logic                  idex_en_out;
  logic                  exmem_en_out;
  logic                  memwb_en_out;
  logic                  ifid_flush_out;
  logic                  idex_flush_out;
  logic                  exmem_flush_out;
  logic                  memwb_flush_out;
  logic                  mul_busy_out;
  logic [1:0]            state_out;
  logic [PERF_WIDTH-1:0] stall_cycles_out;

  modport slave (
    input  mem_wait_in, mul_start_in, branch_taken_in,
    output pc_en_out, ifid_en_out, idex_en_out, exmem_en_out, memwb_en_out,
    output ifid_flush_out, idex_flush_out, exmem_flush_out, memwb_flush_out,
    output mul_busy_out, state_out, stall_cycles_out
  );

  modport master (
    output mem_wait_in, mul_start_in, branch_taken_in,
    input  pc_en_out, ifid_en_out, idex_en_out, exmem_en_out, memwb_en_out,
    input  ifid_flush_out, idex_flush_out, exmem_flush_out, memwb_flush_out,
    input  mul_busy_out, state_out, stall_cycles_out
  );
endinterface

// File: rtl/pipeline_stage_controller.sv
// Sequences enables and synchronous clears of the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers around memory waits, multicycle multiplies and taken branches.
module pipeline_stage_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_WIDTH  = 4,
  parameter int unsigned PERF_WIDTH = 16
) (
  input logic                   clk_in,
  input logic                   reset_in,
  pipeline_stage_controller_if.slave ctrl
);

  localparam logic [1:0] StRun = 2'd0;
  localparam logic [1:0] StMul = 2'd1;

  localparam bit                   MulStalls = (MUL_CYCLES > 1);
  localparam logic [CNT_WIDTH-1:0] MulInit   = CNT_WIDTH'(MUL_CYCLES - 2);

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  mul_cnt_q, mul_cnt_d;
  logic [PERF_WIDTH-1:0] stall_q, stall_d;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic mul_stall;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    mul_stall   = 1'b0;
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;

    if (reset_in) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (ctrl.mem_wait_in) begin
      // Full freeze without clears so the pending load survives.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state_q == StMul) begin
      if (mul_cnt_q != '0) begin
        mul_stall = 1'b1;
        mul_cnt_d = mul_cnt_q - CNT_WIDTH'(1);
      end else begin
        state_d = StRun;
      end
    end else if (ctrl.branch_taken_in) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ctrl.mul_start_in && MulStalls) begin
      mul_stall = 1'b1;
      state_d   = StMul;
      mul_cnt_d = MulInit;
    end

    // Hold the front end and push a bubble into EX/MEM while the multiply occupies EX.
    if (mul_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1)) begin
      stall_d = stall_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= StRun;
      mul_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign ctrl.pc_en_out        = pc_en;
  assign ctrl.ifid_en_out      = ifid_en;
  assign ctrl.idex_en_out      = idex_en;
  assign ctrl.exmem_en_out     = exmem_en;
  assign ctrl.memwb_en_out     = memwb_en;
  assign ctrl.ifid_flush_out   = ifid_flush;
  assign ctrl.idex_flush_out   = idex_flush;
  assign ctrl.exmem_flush_out  = exmem_flush;
  assign ctrl.memwb_flush_out  = memwb_flush;
  assign ctrl.mul_busy_out     = (state_q == StMul);
  assign ctrl.state_out        = state_q;
  assign ctrl.stall_cycles_out = stall_q;

endmodule

// File: doc/pipeline_stage_controller.md
Name: pipeline_stage_controller

Overview:
- Sequences the enables and synchronous clears of the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Each *_en_out drives en_in and each *_flush_out drives reset_in of the matching register. The PC register uses pc_en_out.
- Resolves three hazard sources:
  - data-memory wait (full freeze),
  - multicycle multiply (upstream stall plus EX/MEM bubble),
  - taken branch (flush IF/ID and ID/EX).
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MUL_CYCLES, 4: total cycles a multiply occupies EX, including the start cycle. Legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, 4: width of the multiply cycle counter.
- PERF_WIDTH, 16: width of the stall-cycle counter.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- mem_wait_in  input  1  level; data memory not ready, MEM stage must hold.
- mul_start_in  input  1  EX holds a multiply in its first cycle; sampled only in RUN.
- branch_taken_in  input  1  EX resolved a taken branch this cycle.
- pc_en_out  output  1  PC update enable.
- ifid_en_out, idex_en_out, exmem_en_out, memwb_en_out  output  1 each  pipeline register enables.
- ifid_flush_out, idex_flush_out, exmem_flush_out, memwb_flush_out  output  1 each  pipeline register clears.
- mul_busy_out  output  1  high while state is MUL.
- state_out  output  2  RUN=0, MUL=1.
- stall_cycles_out  output  PERF_WIDTH  count of cycles with pc_en_out=0.

Behaviour:
- State (state, mul_cnt, stall_cycles_out) is registered. Async reset sets state=RUN, mul_cnt=0, stall_cycles_out=0.
- All en/flush outputs are combinational from state, mul_cnt, reset_in and the three inputs. Zero-cycle response.
- Reset asserted: all *_en_out=0, all *_flush_out=1, mul_busy_out=0, state_out=0.
- Priority, highest first: reset, mem_wait_in, state MUL, branch_taken_in, mul_start_in.
- mem_wait_in=1 in any state:
  - all *_en_out=0 and all *_flush_out=0. Flushing would destroy the waiting load.
  - state and mul_cnt hold.
- RUN, no wait, branch_taken_in=1:
  - all en=1, ifid_flush_out=1, idex_flush_out=1, others 0.
  - Stay RUN. mul_start_in is ignored the same cycle.
- RUN, no wait, mul_start_in=1, MUL_CYCLES>1:
  - pc_en_out, ifid_en_out, idex_en_out = 0.
  - exmem_en_out=1 with exmem_flush_out=1, inserting a bubble into EX/MEM.
  - memwb_en_out=1.
  - Next state MUL with mul_cnt=MUL_CYCLES-2.
- RUN, mul_start_in=1, MUL_CYCLES=1: treated as normal RUN; no stall.
- RUN otherwise: all en=1, all flush=0.
- MUL, no wait, mul_cnt>0:
  - same outputs as the MUL start cycle;
  - mul_cnt decrements.
- MUL, no wait, mul_cnt=0:
  - all en=1, flush=0; the multiply result advances;
  - next state RUN.
- MUL: branch_taken_in and mul_start_in are ignored.
- Stall accounting:
  - pc_en_out=0 stalls the front end for exactly MUL_CYCLES-1 cycles per multiply, plus any wait cycles.
  - stall_cycles_out increments on each clock edge where reset is low and pc_en_out=0.
  - It saturates at all-ones; no wrap.
- Reset asserted mid-MUL: state immediately returns to RUN, count discarded, flushes asserted while reset is high.
- Outputs never assert an en=1 with flush=0 on a stage that is also being held.

Test Plan:
- Reset applied then released, no requests.
  - During reset: all flush=1, all en=0.
  - After release: all en=1, all flush=0, state_out=0, stall_cycles_out=0.
- mul_start_in pulse for 1 cycle, MUL_CYCLES=4.
  - pc_en_out=0 for exactly 3 cycles (start + 2 in MUL), exmem_flush_out=1 for those 3 cycles.
  - 4th cycle all en=1; state returns to 0; stall_cycles_out=3.
- mem_wait_in high 2 cycles in the middle of the multiply from the previous scenario.
  - Those cycles: all en=0, all flush=0, mul_cnt frozen.
  - Multiply completes 2 cycles later; stall_cycles_out=5.
- branch_taken_in and mul_start_in both high in RUN.
  - ifid_flush_out=idex_flush_out=1 for 1 cycle; state stays RUN; no stall.
- Reset asserted on the 2nd MUL cycle.
  - state_out=0 immediately, without waiting for a clock edge.
  - After release, normal RUN outputs.
- Force 2^16+5 stall cycles via a long mem_wait_in.
  - stall_cycles_out=16'hFFFF, holds.
